// File: rtl/cmsdk_ahb_default_slave_cfg.sv
// rtl/cmsdk_ahb_default_slave_cfg.sv - AHB-Lite default slave with wait states, ERROR/OKAY response and debug log
// Answers unmapped transfers and records the first offender plus a saturating transfer count.
module cmsdk_ahb_default_slave_cfg #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int RESP_MODE   = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    input  logic                  err_clear,
    output logic                  err_valid,
    output logic                  err_overflow,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ERR1   = 3'd2;
    localparam logic [2:0] S_ERR2   = 3'd3;
    localparam logic [2:0] S_OKDONE = 3'd4;

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [2:0] S_RESP  = (RESP_MODE != 0) ? S_OKDONE : S_ERR1;
    localparam logic [2:0] S_FIRST = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [3:0]           r_wcnt;
    logic                 w_acc;
    logic                 r_valid;
    logic                 r_overflow;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                 r_write;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_unused_htrans0;

    assign w_unused_htrans0 = HTRANS[0];
    assign w_acc = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ERR2, S_OKDONE: w_next = w_acc ? S_FIRST : S_IDLE;
            S_WAIT:                   w_next = (r_wcnt == 4'd0) ? S_RESP : S_WAIT;
            S_ERR1:                   w_next = S_ERR2;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_acc && r_state != S_WAIT && r_state != S_ERR1)
                r_wcnt <= WS_INIT;
            else if (r_state == S_WAIT && r_wcnt != 4'd0)
                r_wcnt <= r_wcnt - 4'd1;
        end
    end

    // A clear coinciding with a new transfer restarts the log with that transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_count    <= '0;
        end else if (w_acc) begin
            if (err_clear || !r_valid) begin
                r_valid    <= 1'b1;
                r_overflow <= 1'b0;
                r_addr     <= HADDR;
                r_write    <= HWRITE;
            end else begin
                r_overflow <= 1'b1;
            end
            if (err_clear)
                r_count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            else if (r_count != CNT_MAX)
                r_count <= r_count + 1'b1;
        end else if (err_clear) begin
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end
    end

    assign HREADYOUT    = !(r_state == S_WAIT || r_state == S_ERR1);
    assign HRESP        = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign HRDATA       = 32'd0;
    assign err_valid    = r_valid;
    assign err_overflow = r_overflow;
    assign err_addr     = r_addr;
    assign err_write    = r_write;
    assign err_count    = r_count;

endmodule

// File: tb/tb_cmsdk_ahb_default_slave_cfg.sv
// tb/tb_cmsdk_ahb_default_slave_cfg.sv - self-checking bench for cmsdk_ahb_default_slave_cfg
// Two configurations (W=0/ERROR/CNT=2 and W=3/OKAY/CNT=8) against a cycle-countdown reference model.
module tb_cmsdk_ahb_default_slave_cfg;

    localparam int PW[2]   = '{0, 3};
    localparam int PM[2]   = '{0, 1};
    localparam int CMAX[2] = '{3, 255};

    logic clk = 1'b0;
    logic rst;
    logic [1:0] hsel, hwrite, hready, eclr;
    logic [1:0] htrans [2];
    logic [31:0] haddr [2];
    logic [1:0] o_rdy, o_resp, o_ev, o_eo, o_ew;
    logic [31:0] o_rd [2];
    logic [31:0] o_ea [2];
    logic [1:0] ec0;
    logic [7:0] ec1;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit rnd = 0;

    int m_left [2];
    bit m_v [2];
    bit m_o [2];
    bit m_w [2];
    logic [31:0] m_a [2];
    int m_c [2];

    always #5 clk = ~clk;

    cmsdk_ahb_default_slave_cfg #(.ADDR_WIDTH(32), .WAIT_STATES(0), .RESP_MODE(0), .CNT_WIDTH(2)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HREADY(hready[0]), .HREADYOUT(o_rdy[0]), .HRESP(o_resp[0]),
        .HRDATA(o_rd[0]), .err_clear(eclr[0]), .err_valid(o_ev[0]), .err_overflow(o_eo[0]),
        .err_addr(o_ea[0]), .err_write(o_ew[0]), .err_count(ec0));

    cmsdk_ahb_default_slave_cfg #(.ADDR_WIDTH(32), .WAIT_STATES(3), .RESP_MODE(1), .CNT_WIDTH(8)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HREADY(hready[1]), .HREADYOUT(o_rdy[1]), .HRESP(o_resp[1]),
        .HRDATA(o_rd[1]), .err_clear(eclr[1]), .err_valid(o_ev[1]), .err_overflow(o_eo[1]),
        .err_addr(o_ea[1]), .err_write(o_ew[1]), .err_count(ec1));

    // m_left = cycles of the current response still to be shown, the present one included.
    function automatic logic exp_rdy(int i);
        return m_left[i] <= 1;
    endfunction

    function automatic logic exp_resp(int i);
        return (PM[i] == 0) && (m_left[i] == 1 || m_left[i] == 2);
    endfunction

    function automatic logic [63:0] cnt_of(int i);
        return (i == 0) ? 64'(ec0) : 64'(ec1);
    endfunction

    task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("hreadyout", i, 64'(o_rdy[i]), 64'(exp_rdy(i)));
                chk("hresp", i, 64'(o_resp[i]), 64'(exp_resp(i)));
                chk("hrdata", i, 64'(o_rd[i]), 64'd0);
                chk("err_valid", i, 64'(o_ev[i]), 64'(m_v[i]));
                chk("err_overflow", i, 64'(o_eo[i]), 64'(m_o[i]));
                chk("err_addr", i, 64'(o_ea[i]), 64'(m_a[i]));
                chk("err_write", i, 64'(o_ew[i]), 64'(m_w[i]));
                chk("err_count", i, cnt_of(i), 64'(m_c[i]));
            end
        end
    end

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = hsel[i] && htrans[i][1] && hready[i];
            if (rst) begin
                m_left[i] = 0; m_v[i] = 0; m_o[i] = 0; m_w[i] = 0; m_a[i] = 0; m_c[i] = 0;
            end else begin
                if (m_left[i] > 0) m_left[i]--;
                if (acc) begin
                    m_left[i] = PW[i] + ((PM[i] != 0) ? 1 : 2);
                    if (eclr[i] || !m_v[i]) begin
                        m_v[i] = 1; m_o[i] = 0; m_a[i] = haddr[i]; m_w[i] = hwrite[i];
                    end else begin
                        m_o[i] = 1;
                    end
                    m_c[i] = eclr[i] ? 1 : ((m_c[i] < CMAX[i]) ? m_c[i] + 1 : m_c[i]);
                end else if (eclr[i]) begin
                    m_v[i] = 0; m_o[i] = 0; m_c[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++)
            hready[i] = (m_left[i] > 0) ? exp_rdy(i) : (rnd ? ($urandom_range(3) != 0) : 1'b1);
    endtask

    task automatic set_xfer(int i, logic [31:0] a, logic w);
        hsel[i] = 1'b1; htrans[i] = 2'b10; haddr[i] = a; hwrite[i] = w;
    endtask

    task automatic set_idle(int i);
        hsel[i] = 1'b0; htrans[i] = 2'b00; haddr[i] = 32'd0; hwrite[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hready = 2'b11; eclr = 2'b00;
        set_idle(0); set_idle(1);
        step(); step();
        rst = 1'b0; chk_en = 1;

        hsel[0] = 1'b1; htrans[0] = 2'b00;
        repeat (3) step();
        chk("t1_count", 0, 64'(ec0), 64'd0);
        chk("t1_rdy", 0, 64'(o_rdy[0]), 64'd1);

        set_xfer(0, 32'h4000_0010, 1'b0);
        step();
        chk("t2_err1_rdy", 0, 64'(o_rdy[0]), 64'd0);
        chk("t2_err1_resp", 0, 64'(o_resp[0]), 64'd1);
        set_idle(0);
        step();
        chk("t2_err2_rdy", 0, 64'(o_rdy[0]), 64'd1);
        chk("t2_err2_resp", 0, 64'(o_resp[0]), 64'd1);
        chk("t2_valid", 0, 64'(o_ev[0]), 64'd1);
        chk("t2_addr", 0, 64'(o_ea[0]), 64'h4000_0010);
        chk("t2_write", 0, 64'(o_ew[0]), 64'd0);

        set_xfer(0, 32'h0000_0044, 1'b1);
        step();
        chk("t4_rdy", 0, 64'(o_rdy[0]), 64'd0);
        chk("t4_resp", 0, 64'(o_resp[0]), 64'd1);
        chk("t4_addr", 0, 64'(o_ea[0]), 64'h4000_0010);
        chk("t4_ovf", 0, 64'(o_eo[0]), 64'd1);
        chk("t4_count", 0, 64'(ec0), 64'd2);

        repeat (6) step();
        chk("t5_sat", 0, 64'(ec0), 64'd3);
        step();
        eclr[0] = 1'b1;
        set_xfer(0, 32'h0000_0088, 1'b0);
        step();
        eclr[0] = 1'b0;
        chk("t5_count", 0, 64'(ec0), 64'd1);
        chk("t5_valid", 0, 64'(o_ev[0]), 64'd1);
        chk("t5_ovf", 0, 64'(o_eo[0]), 64'd0);
        chk("t5_addr", 0, 64'(o_ea[0]), 64'h88);

        set_idle(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rdy", 0, 64'(o_rdy[0]), 64'd1);
        chk("t6_resp", 0, 64'(o_resp[0]), 64'd0);
        chk("t6_valid", 0, 64'(o_ev[0]), 64'd0);
        chk("t6_addr", 0, 64'(o_ea[0]), 64'd0);
        chk("t6_count", 0, 64'(ec0), 64'd0);

        set_xfer(1, 32'h5000_0000, 1'b1);
        step();
        set_idle(1);
        for (int k = 0; k < 3; k++) begin
            chk("t3_wait_rdy", 1, 64'(o_rdy[1]), 64'd0);
            chk("t3_wait_resp", 1, 64'(o_resp[1]), 64'd0);
            step();
        end
        chk("t3_done_rdy", 1, 64'(o_rdy[1]), 64'd1);
        chk("t3_done_resp", 1, 64'(o_resp[1]), 64'd0);
        chk("t3_hrdata", 1, 64'(o_rd[1]), 64'd0);
        chk("t3_write", 1, 64'(o_ew[1]), 64'd1);
        chk("t3_count", 1, 64'(ec1), 64'd1);

        rnd = 1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                hsel[i]   = ($urandom_range(3) != 0);
                htrans[i] = 2'($urandom_range(3));
                haddr[i]  = $urandom;
                hwrite[i] = 1'($urandom_range(1));
                eclr[i]   = ($urandom_range(11) == 0);
            end
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0; eclr = 2'b00;
        set_idle(0); set_idle(1);
        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
